// File: rtl/chunk_row_gen_pkg.sv
// Shared configuration and type definitions for the chunk row generator.
// TauCfg carries the TileAccumUnit-wide sizing defaults; ChunkRowPkg carries
// the command/mode/state encodings and the region sequencing helper.

package TauCfg;
  localparam int GLOBAL_ADDR_BW = 32;
  localparam int CACHE_SIZE     = 32;
  localparam int VSIZE          = 8;
endpackage

package ChunkRowPkg;
  typedef enum logic [1:0] {
    CMD_FETCH = 2'd0,
    CMD_COPY  = 2'd1,
    CMD_ZERO  = 2'd2,
    CMD_EMPTY = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    BM_ZERO  = 2'd0,
    BM_WRAP  = 2'd1,
    BM_CLAMP = 2'd2,
    BM_RSVD  = 2'd3
  } border_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LBORDER = 3'd1,
    ST_CENTER  = 3'd2,
    ST_RBORDER = 3'd3,
    ST_PAD     = 3'd4,
    ST_EMPTY   = 3'd5
  } state_e;

  // Next present region after 'from' in row order. From IDLE with nothing
  // present the row still needs one EMPTY command so islast can travel.
  function automatic state_e next_region(input state_e from, input logic lb_en,
                                         input logic ce_en, input logic rb_en,
                                         input logic pad_en);
    state_e nxt;
    nxt = ST_IDLE;
    case (from)
      ST_IDLE:    nxt = lb_en ? ST_LBORDER : ce_en ? ST_CENTER : rb_en ? ST_RBORDER :
                        pad_en ? ST_PAD : ST_EMPTY;
      ST_LBORDER: nxt = ce_en ? ST_CENTER : rb_en ? ST_RBORDER : pad_en ? ST_PAD : ST_IDLE;
      ST_CENTER:  nxt = rb_en ? ST_RBORDER : pad_en ? ST_PAD : ST_IDLE;
      ST_RBORDER: nxt = pad_en ? ST_PAD : ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction
endpackage

// File: rtl/chunk_row_gen_cursor.sv
// Next-cursor and length for one command inside a region: step by VSIZE,
// optionally stop at the next cache line boundary, never pass the region end.
// Works on distances from the cursor so the caps never overflow.

module chunk_row_cursor #(
  parameter int GBW   = 32,
  parameter int CSIZE = 32,
  parameter int VSIZE = 8,
  parameter int V_BW1 = $clog2(VSIZE + 1)
) (
  input  logic [GBW-1:0]   cur,
  input  logic [GBW-1:0]   region_end,
  input  logic             align_cap,
  output logic [GBW-1:0]   nxt,
  output logic [V_BW1-1:0] len
);
  localparam int C_BW = $clog2(CSIZE);

  logic [GBW-1:0] to_end;
  logic [GBW-1:0] to_line;
  logic [GBW-1:0] step;

  // Smallest of VSIZE, distance to line end (centre only) and distance to region end
  always_comb begin
    to_end  = region_end - cur;
    to_line = GBW'(CSIZE) - GBW'(cur[C_BW-1:0]);
    step    = GBW'(VSIZE);
    if (align_cap && (to_line < step)) step = to_line;
    if (to_end < step) step = to_end;
    nxt = cur + step;
    len = V_BW1'(step);
  end
endmodule

// File: rtl/chunk_row_gen.sv
// Row splitter: turns one row window into LBORDER / CENTER / RBORDER / PAD
// chunk commands (or a single EMPTY). A new row can be taken in the same
// cycle the previous row's final command is acked, so rows stream gaplessly.
// Optional statistics counters are enabled by defining CHUNK_ROW_GEN_STAT_EN.
//
// Handshake: on both the row and command interfaces a transfer happens on a
// rising clock edge where rdy and ack are both high. cmd_rdy and all o_cmd_*
// fields are registered and held until cmd_ack. row_ack is a readiness
// indication and does not depend on row_rdy.

module chunk_row_gen
  import ChunkRowPkg::*;
#(
  parameter int GBW   = TauCfg::GLOBAL_ADDR_BW,
  parameter int CSIZE = TauCfg::CACHE_SIZE,
  parameter int VSIZE = TauCfg::VSIZE,
  parameter int C_BW  = $clog2(CSIZE),
  parameter int V_BW  = $clog2(VSIZE),
  parameter int V_BW1 = $clog2(VSIZE + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             row_rdy,
  output logic             row_ack,
  input  logic [GBW-1:0]   i_row_base,
  input  logic [GBW-1:0]   i_row_l,
  input  logic [GBW-1:0]   i_row_n,
  input  logic [GBW-1:0]   i_row_bound,
  input  logic             i_row_valid,
  input  logic             i_row_islast,
  input  logic [V_BW-1:0]  i_row_pad,
  input  logic [1:0]       i_row_mode,
  output logic             cmd_rdy,
  input  logic             cmd_ack,
  output logic [1:0]       o_cmd_type,
  output logic             o_cmd_islast,
  output logic [GBW-1:0]   o_cmd_addr,
  output logic [C_BW-1:0]  o_cmd_addrofs,
  output logic [V_BW1-1:0] o_cmd_len,
  output logic [2:0]       dbg_state
`ifdef CHUNK_ROW_GEN_STAT_EN
  ,
  output logic [31:0]      o_stat_fetch,
  output logic [31:0]      o_stat_border
`endif
);

  function automatic logic [GBW-1:0] smin(input logic [GBW-1:0] a, input logic [GBW-1:0] b);
    return ($signed(a) < $signed(b)) ? a : b;
  endfunction

  function automatic logic [GBW-1:0] smax(input logic [GBW-1:0] a, input logic [GBW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Row context held for the row currently being split
  state_e         state;
  logic [GBW-1:0] r_cur, r_base, r_bound, r_br;
  logic [GBW-1:0] r_lb_e, r_ce_s, r_ce_e, r_rb_s, r_rb_e;
  logic           r_ce_en, r_rb_en, r_islast;
  logic [V_BW-1:0] r_pad;
  border_mode_e   r_mode;
  logic           cmd_final, cmd_pad, rst_done;

  // Region bounds of the offered row
  logic [GBW-1:0] in_l, in_r, in_br, in_lb_e, in_ce_s, in_ce_e, in_rb_s;
  logic           in_lb_en, in_ce_en, in_rb_en;
  border_mode_e   in_mode;

  // Working context: the offered row when accepting, else the held row
  state_e         s_state, n_state;
  logic [GBW-1:0] s_cur, s_base, s_bound, s_br, s_lb_e, s_ce_s, s_ce_e, s_rb_s, s_rb_e;
  logic           s_ce_en, s_rb_en, s_islast;
  logic [V_BW-1:0] s_pad;
  border_mode_e   s_mode;
  logic [GBW-1:0] s_end, cur_nxt, n_cur, c_addr;
  logic [V_BW1-1:0] cur_len, c_len;
  cmd_type_e      c_type;
  logic           c_final, region_done, accept, gen;

  assign dbg_state = state;
  assign accept    = row_rdy && row_ack;
  assign gen       = (s_state != ST_IDLE) && (!cmd_rdy || cmd_ack);

  // Ready for a row when nothing is in flight, or as the final command leaves
  always_comb begin
    row_ack = rst_done && (((state == ST_IDLE) && !cmd_rdy) ||
                           (cmd_rdy && cmd_ack && cmd_final));
  end

  // Signed region boundaries of the offered row
  always_comb begin
    in_l     = i_row_base + i_row_l;
    in_r     = in_l + i_row_n;
    in_br    = i_row_base + i_row_bound;
    in_lb_e  = i_row_valid ? smin(i_row_base, in_r) : in_r;
    in_lb_en = $signed(in_l) < $signed(in_lb_e);
    in_ce_s  = smax(in_l, i_row_base);
    in_ce_e  = smin(in_r, in_br);
    in_ce_en = i_row_valid && ($signed(in_ce_s) < $signed(in_ce_e));
    in_rb_s  = smax(in_br, in_l);
    in_rb_en = i_row_valid && ($signed(in_rb_s) < $signed(in_r));
    in_mode  = (!i_row_valid || (i_row_mode == 2'd3)) ? BM_ZERO : border_mode_e'(i_row_mode);
  end

  // Pick the context the command generator works from this cycle
  always_comb begin
    if (accept) begin
      s_state = next_region(ST_IDLE, in_lb_en, in_ce_en, in_rb_en, i_row_pad != '0);
      s_cur   = (s_state == ST_CENTER) ? in_ce_s : (s_state == ST_RBORDER) ? in_rb_s : in_l;
      s_base  = i_row_base;  s_bound = i_row_bound; s_br   = in_br;
      s_lb_e  = in_lb_e;     s_ce_s  = in_ce_s;     s_ce_e = in_ce_e;
      s_rb_s  = in_rb_s;     s_rb_e  = in_r;
      s_ce_en = in_ce_en;    s_rb_en = in_rb_en;    s_pad  = i_row_pad;
      s_mode  = in_mode;     s_islast = i_row_islast;
    end else begin
      s_state = state;       s_cur   = r_cur;
      s_base  = r_base;      s_bound = r_bound;     s_br   = r_br;
      s_lb_e  = r_lb_e;      s_ce_s  = r_ce_s;      s_ce_e = r_ce_e;
      s_rb_s  = r_rb_s;      s_rb_e  = r_rb_e;
      s_ce_en = r_ce_en;     s_rb_en = r_rb_en;     s_pad  = r_pad;
      s_mode  = r_mode;      s_islast = r_islast;
    end
  end

  always_comb begin
    s_end = (s_state == ST_LBORDER) ? s_lb_e : (s_state == ST_CENTER) ? s_ce_e : s_rb_e;
  end

  chunk_row_cursor #(.GBW(GBW), .CSIZE(CSIZE), .VSIZE(VSIZE), .V_BW1(V_BW1)) u_cursor (
    .cur        (s_cur),
    .region_end (s_end),
    .align_cap  (s_state == ST_CENTER),
    .nxt        (cur_nxt),
    .len        (cur_len)
  );

  // Command for the current cursor, and where the cursor goes afterwards
  always_comb begin
    region_done = (cur_nxt == s_end) || (s_state == ST_PAD) || (s_state == ST_EMPTY);
    n_state = region_done ? next_region(s_state, 1'b0, s_ce_en, s_rb_en, s_pad != '0) : s_state;
    n_cur   = (region_done && (n_state == ST_CENTER)) ? s_ce_s :
              (region_done && (n_state == ST_RBORDER)) ? s_rb_s : cur_nxt;
    c_final = (n_state == ST_IDLE);
    c_type  = CMD_ZERO;
    c_addr  = '0;
    c_len   = cur_len;
    case (s_state)
      ST_CENTER: begin
        c_type = CMD_FETCH;
        c_addr = s_cur;
      end
      ST_LBORDER, ST_RBORDER: begin
        case (s_mode)
          BM_WRAP: begin
            c_type = CMD_COPY;
            c_addr = (s_state == ST_LBORDER) ? s_cur + s_bound : s_cur - s_bound;
          end
          BM_CLAMP: begin
            c_type = CMD_COPY;
            c_addr = (s_state == ST_LBORDER) ? s_base : s_br - GBW'(1);
          end
          default: begin
            c_type = CMD_ZERO;
            c_addr = '0;
          end
        endcase
      end
      ST_PAD:   c_len = V_BW1'(s_pad);
      ST_EMPTY: begin
        c_type = CMD_EMPTY;
        c_len  = '0;
      end
      default: ;
    endcase
  end

  // Reset release gate for row_ack
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rst_done <= 1'b0;
    else       rst_done <= 1'b1;
  end

  // Latch the accepted row's context; advance the cursor per generated command
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;  r_cur   <= '0;  r_base  <= '0;  r_bound <= '0;
      r_br    <= '0;       r_lb_e  <= '0;  r_ce_s  <= '0;  r_ce_e  <= '0;
      r_rb_s  <= '0;       r_rb_e  <= '0;  r_ce_en <= 1'b0; r_rb_en <= 1'b0;
      r_pad   <= '0;       r_mode  <= BM_ZERO; r_islast <= 1'b0;
    end else begin
      if (accept) begin
        r_base  <= s_base;  r_bound <= s_bound; r_br    <= s_br;
        r_lb_e  <= s_lb_e;  r_ce_s  <= s_ce_s;  r_ce_e  <= s_ce_e;
        r_rb_s  <= s_rb_s;  r_rb_e  <= s_rb_e;  r_ce_en <= s_ce_en;
        r_rb_en <= s_rb_en; r_pad   <= s_pad;   r_mode  <= s_mode;
        r_islast <= s_islast;
      end
      if (gen) begin
        state <= n_state;
        r_cur <= n_cur;
      end
    end
  end

  // Registered command slot, held until acked
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cmd_rdy       <= 1'b0;
      o_cmd_type    <= '0;
      o_cmd_islast  <= 1'b0;
      o_cmd_addr    <= '0;
      o_cmd_addrofs <= '0;
      o_cmd_len     <= '0;
      cmd_final     <= 1'b0;
      cmd_pad       <= 1'b0;
    end else if (gen) begin
      cmd_rdy       <= 1'b1;
      o_cmd_type    <= c_type;
      o_cmd_islast  <= s_islast && c_final;
      o_cmd_addr    <= c_addr & ~GBW'(CSIZE - 1);
      o_cmd_addrofs <= c_addr[C_BW-1:0];
      o_cmd_len     <= c_len;
      cmd_final     <= c_final;
      cmd_pad       <= (s_state == ST_PAD);
    end else if (cmd_ack) begin
      cmd_rdy <= 1'b0;
    end
  end

`ifdef CHUNK_ROW_GEN_STAT_EN
  // Saturating fetch/border counters, cleared when an islast command is acked
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stat_fetch  <= '0;
      o_stat_border <= '0;
    end else if (cmd_rdy && cmd_ack) begin
      if (o_cmd_islast) begin
        o_stat_fetch  <= '0;
        o_stat_border <= '0;
      end else begin
        if ((o_cmd_type == CMD_FETCH) && (o_stat_fetch != '1))
          o_stat_fetch <= o_stat_fetch + 32'd1;
        if (((o_cmd_type == CMD_COPY) || ((o_cmd_type == CMD_ZERO) && !cmd_pad)) &&
            (o_stat_border != '1))
          o_stat_border <= o_stat_border + 32'd1;
      end
    end
  end
`endif

endmodule
